user_wb_mailbox: RTL
====================

// Module: user_wb_mailbox
// PURPOSE
//  Wishbone classic slave that answers the management SoC's exported user-project bus
//  (cyc/stb/we/sel/adr/dat out; ack/dat back). It decodes a small register window.
//  Downstream: CPU writes are pushed into a FIFO and drained by user logic via valid/ready.
//  Upstream: a one-word return register is filled by user logic and read by the CPU.
//  Raises an IRQ toward the user IRQ lines when return data is pending.
// PARAMETERS
//  BASE_ADR     32'h3000_0000  window base; match on wbs_adr_i[31:8]==BASE_ADR[31:8]
//  FIFO_DEPTH   8              downstream FIFO depth; power of 2, >=2
//  WAIT_STATES  0              extra cycles between stb seen and ack (0..7)
// PORTS
//  wb_clk_i     in   1   single clock; all logic on rising edge
//  wb_rst_i     in   1   reset, asynchronous, active-high
//  wbs_cyc_i    in   1   bus cycle
//  wbs_stb_i    in   1   strobe
//  wbs_we_i     in   1   1=write
//  wbs_sel_i    in   4   byte selects
//  wbs_adr_i    in   32  byte address
//  wbs_dat_i    in   32  write data
//  wbs_ack_o    out  1   one-cycle acknowledge
//  wbs_dat_o    out  32  read data, valid with ack, else 0
//  mbox_dout    out  32  FIFO head word
//  mbox_valid   out  1   head valid (!empty & CTRL.en)
//  mbox_ready   in   1   user logic pops on valid&ready
//  ret_data     in   32  return word from user logic
//  ret_valid    in   1   return word offered
//  ret_ready    out  1   = !rx_valid
//  irq_o        out  1   = CTRL.irq_en & rx_valid
// BEHAVIOUR
//  Reset: ack=0, dat_o=0, FIFO empty, mbox_valid=0, mbox_dout=0, rx_valid=0 (ret_ready=1),
//   irq_o=0, CTRL=0, SCRATCH=0, ovf=0. Reset mid-transaction drops ack at once; no side effect.
//  Bus FSM: IDLE -> (cyc&stb&match) WAIT(cnt=WAIT_STATES) -> ACK (ack=1 one cycle) -> IDLE.
//   Ack latency = WAIT_STATES+1 cycles after stb first sampled. Side effects commit only
//   in the ACK cycle. If cyc or stb drops in WAIT, return to IDLE with no ack and no effect.
//   A new transfer is not accepted in the ACK cycle (min 1 idle cycle between acks).
//   No match: no ack (bus times out in the SoC). Unmapped offset inside window: ack, read 0,
//   write ignored.
//  Registers (offset adr[4:2]); writes use full word, wbs_sel_i ignored:
//   0x00 CTRL rw: [0] en, [1] irq_en; [2] flush, write-1 empties FIFO, reads 0.
//   0x04 STATUS: [0] empty [1] full [2] ovf (sticky; write 1 to bit2 clears) [3] rx_valid
//        [15:8] count (0..FIFO_DEPTH, $clog2(FIFO_DEPTH)+1 bits, zero-extended).
//   0x08 TXDATA wo: push; if full (before this cycle's pop) word dropped, ovf=1. Push
//        accepted regardless of en; en gates only mbox_valid. Reads 0.
//   0x0C RXDATA ro: returns rx word; read ACK clears rx_valid. Writes ignored.
//   0x10 SCRATCH rw: plain 32-bit register.
//  FIFO: ptrs wrap modulo FIFO_DEPTH; simultaneous push+pop with count in 1..DEPTH-1 keeps
//   count; push+pop when full drops push (ovf=1), pop proceeds; flush and pop same cycle:
//   flush wins, count=0. mbox_dout=head word when !empty, else 0.
//  Return path: capture ret_data when ret_valid&ret_ready; rx_valid=1. RXDATA read ACK and
//   ret_valid same cycle: clear takes effect; ret_ready is 0 that cycle, capture next cycle.
// CONFIGURATION
//  USER_WB_MBOX_STATS_EN defined: adds 0x14 PUSHCNT ro, 32-bit count of accepted pushes,
//   wraps 0xFFFF_FFFF->0; reset 0; any write to 0x14 clears it.
//   Not defined: 0x14 is unmapped (ack, read 0); no counter logic.
// TESTING
//  - WAIT_STATES=2, read SCRATCH after writing 0xDEAD_BEEF -> ack exactly 3 cycles after stb,
//    dat=0xDEADBEEF; dat_o=0 outside ack.
//  - en=1, push 8 words 1..8 with mbox_ready=0 -> STATUS full=1, count=8; 9th push -> ovf=1;
//    raise ready -> 1..8 popped in order, empty=1.
//  - Full FIFO, push on same cycle as user pop -> word dropped, ovf=1, count=7.
//  - irq_en=1, ret_valid with 0x1234 -> irq_o=1, ret_ready=0; RXDATA read -> 0x1234, irq_o=0.
//  - Drop stb mid-WAIT on TXDATA write, then assert wb_rst_i mid-ACK -> no push, ack=0 at once.
//  - STATS_EN: 5 accepted pushes + 1 overflow -> PUSHCNT=5; write 0x14 -> 0.

Source files
------------

// File: rtl/user_wb_mailbox_if.sv
// Wishbone classic bus bundle between the management SoC (master) and the
// user mailbox (slave).
//   wbs_cyc_i / wbs_stb_i / wbs_we_i  cycle, strobe, write enable (master -> slave)
//   wbs_sel_i [3:0]                    byte selects (master -> slave)
//   wbs_adr_i [31:0]                   byte address (master -> slave)
//   wbs_dat_i [31:0]                   write data (master -> slave)
//   wbs_ack_o                          one-cycle acknowledge (slave -> master)
//   wbs_dat_o [31:0]                   read data, valid with ack (slave -> master)
interface user_wb_mailbox_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/user_wb_mailbox.sv
// user_wb_mailbox: Wishbone classic slave exposing a small mailbox window.
//   Downstream: CPU writes to TXDATA are queued in a FIFO drained by user logic
//   through mbox_dout/mbox_valid/mbox_ready. Upstream: user logic loads a
//   one-word return register (ret_data/ret_valid/ret_ready) read via RXDATA.
//   irq_o is raised while return data is pending and CTRL.irq_en is set.
// Ports:
//   wb_clk_i, wb_rst_i    clock, asynchronous active-high reset
//   wb                    Wishbone slave bundle (user_wb_mailbox_if.slave)
//   mbox_dout/valid/ready FIFO head word, head valid, user pop
//   ret_data/valid/ready  return word handshake
//   irq_o                 interrupt request
// Register map (offset = adr[4:2]): 0x00 CTRL, 0x04 STATUS, 0x08 TXDATA,
//   0x0C RXDATA, 0x10 SCRATCH, 0x14 PUSHCNT (only with USER_WB_MBOX_STATS_EN).
// Optional feature macro: USER_WB_MBOX_STATS_EN (adds the PUSHCNT counter).
module user_wb_mailbox #(
    parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          WAIT_STATES = 0
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    user_wb_mailbox_if.slave   wb,
    output logic [31:0]        mbox_dout,
    output logic               mbox_valid,
    input  logic               mbox_ready,
    input  logic [31:0]        ret_data,
    input  logic               ret_valid,
    output logic               ret_ready,
    output logic               irq_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] OFF_CTRL    = 3'd0;
    localparam logic [2:0] OFF_STATUS  = 3'd1;
    localparam logic [2:0] OFF_TX      = 3'd2;
    localparam logic [2:0] OFF_RX      = 3'd3;
    localparam logic [2:0] OFF_SCRATCH = 3'd4;
    localparam logic [2:0] OFF_PUSHCNT = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;

    logic        en_reg, irq_en_reg, ovf_reg, rx_valid_reg;
    logic [31:0] scratch_reg, rx_data_reg;
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [31:0] mem [FIFO_DEPTH];

    logic        match, ack;
    logic [2:0]  offset;
    logic        wr_ctrl, wr_status, wr_tx, rd_rx, wr_scratch;
    logic        empty, full, push_ok, pop, flush;
    logic [31:0] rdata;

    // Bus pins that carry no information for this block.
    logic        unused_bus;
    assign unused_bus = ^{wb.wbs_sel_i, wb.wbs_adr_i[7:5], wb.wbs_adr_i[1:0]};

    assign match  = (wb.wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign offset = wb.wbs_adr_i[4:2];

    // ---------------- bus FSM ----------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (wb.wbs_cyc_i && wb.wbs_stb_i && match) begin
                    state_next = S_WAIT;
                    cnt_next   = WAIT_STATES[2:0];
                end
            end
            S_WAIT: begin
                // A master that abandons the cycle gets neither ack nor side effect.
                if (!(wb.wbs_cyc_i && wb.wbs_stb_i))
                    state_next = S_IDLE;
                else if (cnt_reg == 3'd0)
                    state_next = S_ACK;
                else
                    cnt_next = cnt_reg - 3'd1;
            end
            S_ACK:   state_next = S_IDLE;  // forces an idle cycle between acks
            default: state_next = S_IDLE;
        endcase
    end

    // Ack is a decode of the state register so reset removes it immediately.
    assign ack = (state_reg == S_ACK);

    // All register side effects commit on the edge that ends the ACK cycle.
    assign wr_ctrl    = ack &&  wb.wbs_we_i && (offset == OFF_CTRL);
    assign wr_status  = ack &&  wb.wbs_we_i && (offset == OFF_STATUS);
    assign wr_tx      = ack &&  wb.wbs_we_i && (offset == OFF_TX);
    assign wr_scratch = ack &&  wb.wbs_we_i && (offset == OFF_SCRATCH);
    assign rd_rx      = ack && !wb.wbs_we_i && (offset == OFF_RX);

    // ---------------- downstream FIFO ----------------
    assign empty   = (count_reg == '0);
    assign full    = (count_reg == FIFO_DEPTH[CW-1:0]);
    assign flush   = wr_ctrl && wb.wbs_dat_i[2];
    // Fullness is judged before this cycle's pop, so a push onto a full FIFO
    // is dropped even if the user pops in the same cycle.
    assign push_ok = wr_tx && !full;
    assign pop     = mbox_valid && mbox_ready;

    assign mbox_valid = !empty && en_reg;
    assign mbox_dout  = empty ? 32'd0 : mem[rd_ptr_reg];

    always_ff @(posedge wb_clk_i) begin
        if (push_ok)
            mem[wr_ptr_reg] <= wb.wbs_dat_i;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ---------------- control / status / return path ----------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            en_reg       <= 1'b0;
            irq_en_reg   <= 1'b0;
            ovf_reg      <= 1'b0;
            scratch_reg  <= '0;
            rx_valid_reg <= 1'b0;
            rx_data_reg  <= '0;
        end else begin
            if (wr_ctrl) begin
                en_reg     <= wb.wbs_dat_i[0];
                irq_en_reg <= wb.wbs_dat_i[1];
            end
            if (wr_tx && full)
                ovf_reg <= 1'b1;
            else if (wr_status && wb.wbs_dat_i[2])
                ovf_reg <= 1'b0;
            if (wr_scratch)
                scratch_reg <= wb.wbs_dat_i;
            // ret_ready is low whenever rx_valid is set, so clear and capture
            // never coincide; a pending offer is taken the cycle after a clear.
            if (rd_rx)
                rx_valid_reg <= 1'b0;
            else if (ret_valid && ret_ready) begin
                rx_valid_reg <= 1'b1;
                rx_data_reg  <= ret_data;
            end
        end
    end

    assign ret_ready = !rx_valid_reg;
    assign irq_o     = irq_en_reg && rx_valid_reg;

`ifdef USER_WB_MBOX_STATS_EN
    logic [31:0] pushcnt_reg;
    logic        wr_pushcnt;
    assign wr_pushcnt = ack && wb.wbs_we_i && (offset == OFF_PUSHCNT);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            pushcnt_reg <= '0;
        else if (wr_pushcnt)
            pushcnt_reg <= '0;
        else if (push_ok)
            pushcnt_reg <= pushcnt_reg + 32'd1;
    end
`endif

    // ---------------- read mux ----------------
    always_comb begin
        rdata = '0;
        case (offset)
            OFF_CTRL:    rdata[1:0] = {irq_en_reg, en_reg};
            OFF_STATUS: begin
                rdata[0]       = empty;
                rdata[1]       = full;
                rdata[2]       = ovf_reg;
                rdata[3]       = rx_valid_reg;
                rdata[8 +: CW] = count_reg;
            end
            OFF_RX:      rdata = rx_data_reg;
            OFF_SCRATCH: rdata = scratch_reg;
`ifdef USER_WB_MBOX_STATS_EN
            OFF_PUSHCNT: rdata = pushcnt_reg;
`endif
            default:     rdata = '0;
        endcase
    end

    assign wb.wbs_ack_o = ack;
    assign wb.wbs_dat_o = ack ? rdata : 32'd0;
endmodule
